// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch-stage program-counter sequencer: condition codes,
// branch kinds, FSM states and flag bit positions.
package pc_seq_pkg;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef enum logic [1:0] {
    BR_SEQ, BR_REG, BR_REL, BR_LINK
  } br_e;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_HALT
  } state_e;

  // Bit positions within the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_redirect(input br_e br);
    return (br != BR_SEQ);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the pipeline front-end and the PC sequencer.
// master = pipeline control that drives requests, slave = the sequencer.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IMM_W = 24
);
  logic              start;
  logic              halt;
  logic              stall;
  br_e               Branch;
  cond_e             Cond;
  logic              FlagsWrite;
  logic [3:0]        ALUFlags;
  logic [IMM_W-1:0]  Imm;
  logic [XLEN-1:0]   RegTarget;
  logic [XLEN-1:0]   PC;
  logic              PCSrc;
  logic              LinkWE;
  logic [XLEN-1:0]   LinkAddr;
  logic              Running;
  logic              Halted;

  modport master (
    output start, halt, stall, Branch, Cond, FlagsWrite, ALUFlags, Imm, RegTarget,
    input  PC, PCSrc, LinkWE, LinkAddr, Running, Halted
  );

  modport slave (
    input  start, halt, stall, Branch, Cond, FlagsWrite, ALUFlags, Imm, RegTarget,
    output PC, PCSrc, LinkWE, LinkAddr, Running, Halted
  );

endinterface

// File: rtl/pc_sequencer_cond_eval.sv
// Combinational ARM-style condition evaluation of a condition code against {N,Z,C,V}.
module cond_eval
  import pc_seq_pkg::*;
(
  input  cond_e       cond,
  input  logic [3:0]  flags,
  output logic        cond_ex
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Condition code decode
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      EQ:      cond_ex = z_s;
      NE:      cond_ex = ~z_s;
      CS:      cond_ex = c_s;
      CC:      cond_ex = ~c_s;
      MI:      cond_ex = n_s;
      PL:      cond_ex = ~n_s;
      VS:      cond_ex = v_s;
      VC:      cond_ex = ~v_s;
      HI:      cond_ex = c_s & ~z_s;
      LS:      cond_ex = ~c_s | z_s;
      GE:      cond_ex = (n_s == v_s);
      LT:      cond_ex = (n_s != v_s);
      GT:      cond_ex = ~z_s & (n_s == v_s);
      LE:      cond_ex = z_s | (n_s != v_s);
      AL:      cond_ex = 1'b1;
      NV:      cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: start/halt FSM, registered ALU flags, and next-PC
// selection among sequential, PC-relative, branch-and-link and register jump.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              IMM_W       = 24,
  parameter int              IMM_SHIFT   = 0,
  parameter int              INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VEC   = {XLEN{1'b0}}
)
(
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);

  state_e            state_r;
  state_e            state_next_s;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   pc_next_s;
  logic [3:0]        flags_r;
  logic              pcsrc_r;
  logic              pcsrc_next_s;
  logic              linkwe_r;
  logic              linkwe_next_s;
  logic [XLEN-1:0]   linkaddr_r;
  logic [XLEN-1:0]   linkaddr_next_s;
  logic              running_r;
  logic              halted_r;
  logic              cond_ex_s;
  logic              taken_s;
  logic [XLEN-1:0]   imm_ext_s;
  logic [XLEN-1:0]   rel_target_s;
  logic [XLEN-1:0]   seq_pc_s;

  cond_eval u_cond_eval (
    .cond    (bus.Cond),
    .flags   (flags_r),
    .cond_ex (cond_ex_s)
  );

  // Flags are evaluated from the register, so a write this cycle only affects the next one
  assign taken_s      = cond_ex_s & is_redirect(bus.Branch);
  assign imm_ext_s    = {{(XLEN-IMM_W){bus.Imm[IMM_W-1]}}, bus.Imm};
  assign rel_target_s = pc_r + (imm_ext_s << IMM_SHIFT);
  assign seq_pc_s     = pc_r + XLEN'(INSTR_BYTES);

  // Next-state and next-PC selection; halt > stall > branch > sequential
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    pcsrc_next_s    = 1'b0;
    linkwe_next_s   = 1'b0;
    linkaddr_next_s = linkaddr_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.halt) begin
          state_next_s = S_HALT;
        end else if (bus.stall) begin
          pc_next_s = pc_r;
        end else if (taken_s) begin
          pcsrc_next_s = 1'b1;
          case (bus.Branch)
            BR_REG:  pc_next_s = bus.RegTarget;
            BR_REL:  pc_next_s = rel_target_s;
            BR_LINK: begin
              pc_next_s       = rel_target_s;
              linkwe_next_s   = 1'b1;
              linkaddr_next_s = seq_pc_s;
            end
            default: pc_next_s = seq_pc_s;
          endcase
        end else begin
          pc_next_s = seq_pc_s;
        end
      end
      S_HALT: begin
        state_next_s = S_HALT;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, PC and link registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      pc_r       <= RESET_VEC;
      pcsrc_r    <= 1'b0;
      linkwe_r   <= 1'b0;
      linkaddr_r <= {XLEN{1'b0}};
      running_r  <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      pcsrc_r    <= pcsrc_next_s;
      linkwe_r   <= linkwe_next_s;
      linkaddr_r <= linkaddr_next_s;
      running_r  <= (state_next_s == S_RUN);
      halted_r   <= (state_next_s == S_HALT);
    end
  end

  // Flag register, written in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if (bus.FlagsWrite) begin
      flags_r <= bus.ALUFlags;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign bus.PC       = pc_r;
  assign bus.PCSrc    = pcsrc_r;
  assign bus.LinkWE   = linkwe_r;
  assign bus.LinkAddr = linkaddr_r;
  assign bus.Running  = running_r;
  assign bus.Halted   = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the sequencer.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  string phase = "init";

  logic [31:0] m_pc;
  logic [31:0] m_linkaddr;
  logic [3:0]  m_flags;
  bit          m_run;
  bit          m_halt;
  bit          m_pcsrc;
  bit          m_linkwe;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Table lookup of the condition truth value, indexed by the 4-bit code
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    bit tbl [16];
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    tbl = '{z, !z, cy, !cy, n, !n, v, !v,
            cy && !z, !cy || z, n == v, n != v,
            !z && (n == v), z || (n != v), 1'b1, 1'b0};
    return tbl[c];
  endfunction

  task automatic clear_inputs();
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.halt       = 1'b0;
    bus.stall      = 1'b0;
    bus.Branch     = BR_SEQ;
    bus.Cond       = AL;
    bus.FlagsWrite = 1'b0;
    bus.ALUFlags   = 4'b0000;
    bus.Imm        = 24'h000000;
    bus.RegTarget  = 32'h0000_0000;
  endtask

  // Advance one clock: predict from current inputs, then compare every output
  task automatic step();
    logic [31:0] n_pc, n_la;
    logic [3:0]  n_flags;
    bit          n_run, n_halt, n_pcsrc, n_linkwe, tk;
    int          off;
    n_pc = m_pc; n_la = m_linkaddr; n_flags = m_flags;
    n_run = m_run; n_halt = m_halt; n_pcsrc = 1'b0; n_linkwe = 1'b0;
    if (reset) begin
      n_pc = 32'h0; n_la = 32'h0; n_flags = 4'h0;
      n_run = 1'b0; n_halt = 1'b0;
    end else begin
      if (bus.FlagsWrite) n_flags = bus.ALUFlags;
      if (!m_run && !m_halt) begin
        n_run = bus.start;
      end else if (m_run) begin
        if (bus.halt) begin
          n_run = 1'b0; n_halt = 1'b1;
        end else if (!bus.stall) begin
          tk  = ref_cond(bus.Cond, m_flags) && (bus.Branch != BR_SEQ);
          off = $signed(bus.Imm);
          if (!tk) n_pc = m_pc + 32'd4;
          else if (bus.Branch == BR_REG) n_pc = bus.RegTarget;
          else n_pc = m_pc + 32'(off);
          n_pcsrc = tk;
          if (tk && bus.Branch == BR_LINK) begin
            n_linkwe = 1'b1;
            n_la     = m_pc + 32'd4;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_linkaddr = n_la; m_flags = n_flags;
    m_run = n_run; m_halt = n_halt; m_pcsrc = n_pcsrc; m_linkwe = n_linkwe;
    check_value("PC",       bus.PC,            m_pc);
    check_value("PCSrc",    32'(bus.PCSrc),    32'(m_pcsrc));
    check_value("LinkWE",   32'(bus.LinkWE),   32'(m_linkwe));
    check_value("LinkAddr", bus.LinkAddr,      m_linkaddr);
    check_value("Running",  32'(bus.Running),  32'(m_run));
    check_value("Halted",   32'(bus.Halted),   32'(m_halt));
  endtask

  task automatic reset_and_start();
    clear_inputs();
    reset = 1'b1; step();
    reset = 1'b0; bus.start = 1'b1; step();
    bus.start = 1'b0;
  endtask

  initial begin
    m_pc = 32'h0; m_linkaddr = 32'h0; m_flags = 4'h0;
    m_run = 1'b0; m_halt = 1'b0; m_pcsrc = 1'b0; m_linkwe = 1'b0;
    clear_inputs();

    phase = "reset_seq";
    reset = 1'b1; step();
    check_value("rst_pc", bus.PC, 32'h0);
    check_value("rst_running", 32'(bus.Running), 32'h0);
    reset = 1'b0; bus.start = 1'b1; step();
    bus.start = 1'b0;
    check_value("start_pc", bus.PC, 32'h0);
    check_value("start_running", 32'(bus.Running), 32'h1);
    repeat (4) step();
    check_value("seq4_pc", bus.PC, 32'h10);

    phase = "cond_branch";
    reset_and_start();
    bus.FlagsWrite = 1'b1; bus.ALUFlags = 4'b0100; step();
    bus.FlagsWrite = 1'b0; step();
    check_value("pre_pc", bus.PC, 32'h8);
    bus.Branch = BR_REL; bus.Cond = EQ; bus.Imm = 24'h000010; step();
    check_value("eq_pc", bus.PC, 32'h18);
    check_value("eq_pcsrc", 32'(bus.PCSrc), 32'h1);
    bus.Branch = BR_SEQ; step();
    check_value("pcsrc_drop", 32'(bus.PCSrc), 32'h0);
    bus.Branch = BR_REL; bus.Cond = NE; step();
    check_value("ne_pc", bus.PC, 32'h20);
    check_value("ne_pcsrc", 32'(bus.PCSrc), 32'h0);
    bus.Cond = EQ; bus.Imm = 24'hFFFFF8; step();
    check_value("neg_pc", bus.PC, 32'h18);

    phase = "link_stall";
    reset_and_start();
    repeat (4) step();
    bus.Branch = BR_LINK; bus.Cond = AL; bus.Imm = 24'h000040; step();
    check_value("bl_pc", bus.PC, 32'h50);
    check_value("bl_linkwe", 32'(bus.LinkWE), 32'h1);
    check_value("bl_linkaddr", bus.LinkAddr, 32'h14);
    bus.Branch = BR_SEQ; step();
    check_value("bl_linkwe_drop", 32'(bus.LinkWE), 32'h0);
    bus.Branch = BR_REL; bus.Imm = 24'h000010; bus.stall = 1'b1; step();
    check_value("stall_pc", bus.PC, 32'h54);
    check_value("stall_pcsrc", 32'(bus.PCSrc), 32'h0);
    bus.stall = 1'b0; step();
    check_value("unstall_pc", bus.PC, 32'h64);

    phase = "halt";
    bus.halt = 1'b1; step();
    bus.halt = 1'b0;
    check_value("halt_pc", bus.PC, 32'h64);
    check_value("halt_halted", 32'(bus.Halted), 32'h1);
    bus.start = 1'b1; bus.FlagsWrite = 1'b1; bus.ALUFlags = 4'b1010; step();
    check_value("halt_start_ign", 32'(bus.Halted), 32'h1);
    bus.start = 1'b0; bus.FlagsWrite = 1'b0;
    reset = 1'b1; step();
    reset = 1'b0;
    check_value("halt_rst_pc", bus.PC, 32'h0);
    check_value("halt_rst_halted", 32'(bus.Halted), 32'h0);

    phase = "wrap_flags";
    bus.start = 1'b1; step();
    bus.start = 1'b0;
    bus.Branch = BR_REG; bus.Cond = AL; bus.RegTarget = 32'hFFFF_FFFC; step();
    check_value("jr_pc", bus.PC, 32'hFFFF_FFFC);
    bus.Branch = BR_SEQ; step();
    check_value("wrap_pc", bus.PC, 32'h0);
    bus.FlagsWrite = 1'b1; bus.ALUFlags = 4'b0100;
    bus.Branch = BR_REL; bus.Cond = EQ; bus.Imm = 24'h000100; step();
    check_value("old_z_pc", bus.PC, 32'h4);
    bus.FlagsWrite = 1'b0; step();
    check_value("new_z_pc", bus.PC, 32'h104);

    phase = "random";
    clear_inputs();
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      bus.start      = ($urandom_range(0, 7) == 0);
      bus.halt       = ($urandom_range(0, 59) == 0);
      bus.stall      = ($urandom_range(0, 3) == 0);
      bus.Branch     = br_e'(2'($urandom));
      bus.Cond       = cond_e'(4'($urandom));
      bus.FlagsWrite = ($urandom_range(0, 2) == 0);
      bus.ALUFlags   = 4'($urandom);
      bus.Imm        = 24'($urandom);
      bus.RegTarget  = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
